// File: rtl/mem_arbiter.sv
// Arbitrates one line-wide memory port between I-cache and D-cache miss traffic.
// Optional feature: define ARB_RR_EN for round-robin on simultaneous requests (default: D priority with starvation override).
module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;
    logic [LINE_W-1:0]   i_rdata_q;
    logic [LINE_W-1:0]   d_rdata_q;
    logic                i_ready_q;
    logic                d_ready_q;

    logic req_i;
    logic req_d;
    logic gnt_i;
    logic gnt_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

`ifdef ARB_RR_EN
    // ptr_q high means D wins the next tie
    logic ptr_q;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (state_q == IDLE) begin
            if (req_i && req_d) begin
                gnt_d = ptr_q;
                gnt_i = !ptr_q;
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            ptr_q <= 1'b1;
        end else if (gnt_d) begin
            ptr_q <= 1'b0;
        end else if (gnt_i) begin
            ptr_q <= 1'b1;
        end
    end
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (state_q == IDLE) begin
            if (req_i && req_d) begin
                gnt_i = (starve_q == STARVE_MAX);
                gnt_d = (starve_q != STARVE_MAX);
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
        end
    end

    // counts D wins that I had to sit through; any gap in I's request restarts it
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            starve_q <= '0;
        end else if (!req_i || gnt_i) begin
            starve_q <= '0;
        end else if (gnt_d && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_d) begin
                        state_q     <= BUSY_D;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_write_q <= d_write;
                        mem_read_q  <= !d_write;
                    end else if (gnt_i) begin
                        state_q     <= BUSY_I;
                        mem_addr_q  <= i_addr;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        state_q     <= RELEASE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        i_rdata_q   <= mem_rdata;
                        i_ready_q   <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state_q     <= RELEASE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        d_rdata_q   <= mem_rdata;
                        d_ready_q   <= 1'b1;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: cache requesters and a latency-programmable memory model.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          proc_reset = 1'b1;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    mem_arbiter dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic          rd;
        logic [LW-1:0] wdata;
        int            cyc;
    } gnt_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } dreq_t;

    typedef struct {
        logic          chk;
        logic [LW-1:0] data;
    } dexp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int unstable = 0;
    int mem_lat = 3;
    int mem_cnt = 0;
    logic          strobe_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;

    logic [AW-1:0] i_q[$];
    dreq_t         d_q[$];
    gnt_t          obs_g[$];
    gnt_t          exp_g[$];
    logic [LW-1:0] obs_i[$];
    logic [LW-1:0] exp_i[$];
    logic [LW-1:0] obs_d[$];
    dexp_t         exp_d[$];
    int            obs_i_cyc[$];
    int            obs_d_cyc[$];

    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        if (a == 28'h0000010) return {16{8'hA5}};
        return {a, 4'h1, ~a, 4'h2, a ^ 28'h5A5A5A5, 4'h3, a + 28'h1234567, 4'h4};
    endfunction

    function automatic gnt_t mk_g(input logic [AW-1:0] a, input logic wr, input logic [LW-1:0] wd);
        gnt_t g;
        g.addr = a; g.wr = wr; g.rd = !wr; g.wdata = wd; g.cyc = 0;
        return g;
    endfunction

    // memory: counts strobe cycles, raises mem_ready for one cycle after mem_lat of them
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (proc_reset) begin
            mem_cnt = 0;
        end else if (mem_read || mem_write) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_read ? line_for(mem_addr) : {4{32'hDEADBEEF}};
                mem_cnt = 0;
            end
        end
    end

    task automatic push_i(input logic [AW-1:0] a);
        i_q.push_back(a);
        exp_i.push_back(line_for(a));
    endtask

    task automatic push_d(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        dreq_t r;
        dexp_t e;
        r.wr = wr; r.addr = a; r.wdata = wd;
        d_q.push_back(r);
        e.chk = !wr; e.data = line_for(a);
        exp_d.push_back(e);
    endtask

    task automatic clear_obs();
        obs_g.delete(); obs_i.delete(); obs_d.delete();
        obs_i_cyc.delete(); obs_d_cyc.delete();
        unstable = 0;
    endtask

    // cache agents plus bus observer; records events only
    task automatic run(input int max_cyc, input bit until_idle, output bit timed_out);
        logic strobe;
        gnt_t g;
        timed_out = until_idle;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            cyc++;
            strobe = mem_read | mem_write;
            if (strobe && !strobe_prev) begin
                g.addr = mem_addr; g.wr = mem_write; g.rd = mem_read; g.wdata = mem_wdata; g.cyc = cyc;
                obs_g.push_back(g);
            end else if (strobe && strobe_prev && mem_addr !== addr_prev) begin
                unstable++;
            end
            strobe_prev = strobe;
            addr_prev = mem_addr;
            if (i_ready) begin
                obs_i.push_back(i_rdata); obs_i_cyc.push_back(cyc);
                if (i_q.size() > 0) void'(i_q.pop_front());
            end
            if (d_ready) begin
                obs_d.push_back(d_rdata); obs_d_cyc.push_back(cyc);
                if (d_q.size() > 0) void'(d_q.pop_front());
            end
            i_read  = (i_q.size() > 0);
            i_addr  = (i_q.size() > 0) ? i_q[0] : '0;
            d_read  = (d_q.size() > 0) && !d_q[0].wr;
            d_write = (d_q.size() > 0) && d_q[0].wr;
            d_addr  = (d_q.size() > 0) ? d_q[0].addr : '0;
            d_wdata = (d_q.size() > 0) ? d_q[0].wdata : '0;
            if (until_idle && i_q.size() == 0 && d_q.size() == 0 && !strobe && !i_ready && !d_ready) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes got %b want 0000", {mem_read, mem_write, i_ready, d_ready});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL reset_membus got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata got i %h d %h want 0", i_rdata, d_rdata);
        end
        proc_reset = 1'b0;
    endtask

    task automatic test_isolated_i();
        bit to;
        gnt_t og;
        int base;
        clear_obs();
        mem_lat = 5;
        base = cyc;
        push_i(28'h0000010);
        exp_g.push_back(mk_g(28'h0000010, 1'b0, '0));
        run(60, 1'b1, to);
        checks++;
        if (to) begin errors++; $display("FAIL iso_timeout got timeout want completion"); end
        checks++;
        if (obs_g.size() != 1) begin
            errors++; $display("FAIL iso_grants got %0d want 1", obs_g.size());
        end else begin
            og = obs_g.pop_front();
            void'(exp_g.pop_front());
            checks++;
            if (og.addr !== 28'h0000010 || og.rd !== 1'b1 || og.wr !== 1'b0) begin
                errors++; $display("FAIL iso_bus got addr %h rd %b wr %b want 0000010 1 0", og.addr, og.rd, og.wr);
            end
            checks++;
            if (og.cyc != base + 2) begin
                errors++; $display("FAIL iso_strobe_cycle got %0d want %0d", og.cyc - base - 1, 1);
            end
            checks++;
            if (obs_i_cyc.size() != 1 || obs_i_cyc[0] != og.cyc + 5) begin
                errors++; $display("FAIL iso_ready_cycle got %0d pulses want 1 at grant+5", obs_i_cyc.size());
            end
        end
        checks++;
        if (obs_i.size() != 1 || obs_i[0] !== exp_i[0]) begin
            errors++; $display("FAIL iso_rdata got %0d pulses want 1 with %h", obs_i.size(), exp_i[0]);
        end
        exp_i.delete();
        checks++;
        if (obs_d.size() != 0) begin errors++; $display("FAIL iso_d_ready got %0d pulses want 0", obs_d.size()); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL iso_stable got %0d changes want 0", unstable); end
    endtask

    task automatic test_d_writeback();
        bit to;
        gnt_t og;
        logic [LW-1:0] wd;
        clear_obs();
        mem_lat = 3;
        wd = 128'h123456789ABCDEF0_0FEDCBA987654321;
        push_d(1'b1, 28'h0000200, wd);
        exp_g.push_back(mk_g(28'h0000200, 1'b1, wd));
        run(60, 1'b1, to);
        checks++;
        if (to) begin errors++; $display("FAIL wb_timeout got timeout want completion"); end
        while (exp_g.size() > 0) begin
            gnt_t eg;
            eg = exp_g.pop_front();
            checks++;
            if (obs_g.size() == 0) begin
                errors++; $display("FAIL wb_grant got none want addr %h", eg.addr);
            end else begin
                og = obs_g.pop_front();
                if (og.addr !== eg.addr || og.wr !== 1'b1 || og.rd !== 1'b0 || og.wdata !== eg.wdata) begin
                    errors++; $display("FAIL wb_bus got addr %h wr %b rd %b wdata %h want %h 1 0 %h",
                                       og.addr, og.wr, og.rd, og.wdata, eg.addr, eg.wdata);
                end
            end
        end
        checks++;
        if (obs_d.size() != 1 || obs_i.size() != 0) begin
            errors++; $display("FAIL wb_ready got d %0d i %0d pulses want 1 0", obs_d.size(), obs_i.size());
        end
        exp_d.delete();
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++; $display("FAIL wb_idle got rd %b wr %b want 0 0", mem_read, mem_write);
        end
    endtask

    // both caches queue traffic together; grant order comes from the arbitration rule
    task automatic test_contention(input string name);
        bit to;
        gnt_t og;
        gnt_t eg;
        dexp_t ed;
        run(400, 1'b1, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout got timeout want completion", name); end
        while (exp_g.size() > 0) begin
            eg = exp_g.pop_front();
            checks++;
            if (obs_g.size() == 0) begin
                errors++; $display("FAIL %s_grant got none want addr %h", name, eg.addr);
            end else begin
                og = obs_g.pop_front();
                if (og.addr !== eg.addr || og.wr !== eg.wr || og.rd !== eg.rd || (eg.wr && og.wdata !== eg.wdata)) begin
                    errors++; $display("FAIL %s_grant got addr %h wr %b want addr %h wr %b", name, og.addr, og.wr, eg.addr, eg.wr);
                end
            end
        end
        while (exp_i.size() > 0) begin
            logic [LW-1:0] ei;
            ei = exp_i.pop_front();
            checks++;
            if (obs_i.size() == 0) begin
                errors++; $display("FAIL %s_i_data got none want %h", name, ei);
            end else if (obs_i[0] !== ei) begin
                errors++; $display("FAIL %s_i_data got %h want %h", name, obs_i[0], ei);
                void'(obs_i.pop_front());
            end else begin
                void'(obs_i.pop_front());
            end
        end
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            checks++;
            if (obs_d.size() == 0) begin
                errors++; $display("FAIL %s_d_data got none want %h", name, ed.data);
            end else begin
                if (ed.chk && obs_d[0] !== ed.data) begin
                    errors++; $display("FAIL %s_d_data got %h want %h", name, obs_d[0], ed.data);
                end
                void'(obs_d.pop_front());
            end
        end
        checks++;
        if (obs_g.size() != 0 || obs_i.size() != 0 || obs_d.size() != 0) begin
            errors++; $display("FAIL %s_extra got g %0d i %0d d %0d want 0 0 0", name, obs_g.size(), obs_i.size(), obs_d.size());
        end
    endtask

    task automatic test_simultaneous();
        bit to;
        int d_rdy;
        int i_gnt;
        clear_obs();
        mem_lat = 4;
        push_i(28'h0000030);
        push_d(1'b0, 28'h0000040, '0);
        exp_g.push_back(mk_g(28'h0000040, 1'b0, '0));
        exp_g.push_back(mk_g(28'h0000030, 1'b0, '0));
        run(100, 1'b1, to);
        d_rdy = (obs_d_cyc.size() > 0) ? obs_d_cyc[0] : -100;
        i_gnt = (obs_g.size() > 1) ? obs_g[1].cyc : -1;
        checks++;
        if (i_gnt != d_rdy + 2) begin
            errors++; $display("FAIL sim_i_grant_cycle got %0d want %0d", i_gnt, d_rdy + 2);
        end
        checks++;
        if (to) begin errors++; $display("FAIL sim_timeout got timeout want completion"); end
        test_contention("sim");
    endtask

    task automatic test_starvation();
        clear_obs();
        mem_lat = 2;
        for (int k = 0; k < 6; k++) push_d(1'b0, 28'h0000100 + AW'(k), '0);
        push_i(28'h0000050);
`ifdef ARB_RR_EN
        exp_g.push_back(mk_g(28'h0000100, 1'b0, '0));
        exp_g.push_back(mk_g(28'h0000050, 1'b0, '0));
        for (int k = 1; k < 6; k++) exp_g.push_back(mk_g(28'h0000100 + AW'(k), 1'b0, '0));
`else
        for (int k = 0; k < 4; k++) exp_g.push_back(mk_g(28'h0000100 + AW'(k), 1'b0, '0));
        exp_g.push_back(mk_g(28'h0000050, 1'b0, '0));
        for (int k = 4; k < 6; k++) exp_g.push_back(mk_g(28'h0000100 + AW'(k), 1'b0, '0));
`endif
        test_contention("starve");
    endtask

    task automatic test_both_continuous();
        logic [LW-1:0] wd;
        clear_obs();
        mem_lat = 1;
        wd = {4{32'hCAFEF00D}};
        for (int k = 0; k < 3; k++) push_i(28'h0000060 + AW'(k));
        push_d(1'b0, 28'h0000070, '0);
        push_d(1'b1, 28'h0000071, wd);
        push_d(1'b0, 28'h0000072, '0);
`ifdef ARB_RR_EN
        exp_g.push_back(mk_g(28'h0000070, 1'b0, '0));
        exp_g.push_back(mk_g(28'h0000060, 1'b0, '0));
        exp_g.push_back(mk_g(28'h0000071, 1'b1, wd));
        exp_g.push_back(mk_g(28'h0000061, 1'b0, '0));
        exp_g.push_back(mk_g(28'h0000072, 1'b0, '0));
        exp_g.push_back(mk_g(28'h0000062, 1'b0, '0));
`else
        exp_g.push_back(mk_g(28'h0000070, 1'b0, '0));
        exp_g.push_back(mk_g(28'h0000071, 1'b1, wd));
        exp_g.push_back(mk_g(28'h0000072, 1'b0, '0));
        for (int k = 0; k < 3; k++) exp_g.push_back(mk_g(28'h0000060 + AW'(k), 1'b0, '0));
`endif
        test_contention("both");
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_obs();
        mem_lat = 20;
        push_d(1'b0, 28'h0000300, '0);
        run(6, 1'b0, to);
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000300) begin
            errors++; $display("FAIL rst_mid_busy got rd %b addr %h want 1 0000300", mem_read, mem_addr);
        end
        #2 proc_reset = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0) begin
            errors++; $display("FAIL rst_mid_async got rd %b wr %b addr %h want 0 0 0", mem_read, mem_write, mem_addr);
        end
        d_q.delete(); exp_d.delete();
        d_read = 1'b0; d_write = 1'b0; d_addr = '0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_d_ready got 1 want 0"); end
        end
        proc_reset = 1'b0;
        strobe_prev = 1'b0;
        clear_obs();
        mem_lat = 2;
        push_i(28'h0000044);
        exp_g.push_back(mk_g(28'h0000044, 1'b0, '0));
        test_contention("rst_fresh");
    endtask

    initial begin
        test_reset();
        test_isolated_i();
        test_d_writeback();
        test_simultaneous();
        test_starvation();
        test_both_continuous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified slow memory port (128-bit line, 28-bit line address) between the I-cache and D-cache miss interfaces.
- Sits between the two cache instances and the external memory.
- Grants one requester at a time, registers the request onto the memory bus, and holds it until memory ready.
- Returns the line data and a one-cycle ready pulse to the granted cache.

Parameters:
- ADDR_W, 28, line address width (address bits [31:4]).
- LINE_W, 128, cache line / memory data width.
- STARVE_LIMIT, 4, consecutive D grants while I is waiting after which I is forced next (fixed-priority mode only).

Ports:
- clk  input  1  single clock, rising edge.
- proc_reset  input  1  asynchronous, active-high reset.
- i_read  input  1  I-cache line read request; held until i_ready.
- i_addr  input  ADDR_W  I-cache line address.
- i_rdata  output  LINE_W  line returned to I-cache.
- i_ready  output  1  one-cycle completion pulse to I-cache.
- d_read  input  1  D-cache line read request.
- d_write  input  1  D-cache line write-back request; never asserted together with d_read.
- d_addr  input  ADDR_W  D-cache line address.
- d_wdata  input  LINE_W  D-cache write-back line.
- d_rdata  output  LINE_W  line returned to D-cache.
- d_ready  output  1  one-cycle completion pulse to D-cache.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory line address.
- mem_wdata  output  LINE_W  memory write data.
- mem_rdata  input  LINE_W  memory read data, valid with mem_ready.
- mem_ready  input  1  memory completion, one cycle.

Behaviour:
- Reset (async, active-high) clears everything immediately: state=IDLE, all mem_* outputs 0, i_ready/d_ready 0, i_rdata/d_rdata 0, starve counter 0, rr pointer = D.
- An in-flight memory transaction is abandoned on reset; no ready pulse is issued for it.
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE arbitration, sampled each cycle on req_i=i_read and req_d=d_read|d_write:
  - neither requesting: stay IDLE.
  - one requesting: grant it.
  - both requesting: grant D, unless starve counter == STARVE_LIMIT, in which case grant I.
- On grant (IDLE -> BUSY_x):
  - latch address, operation and (for D) wdata into registers.
  - mem_read/mem_write are driven from registers starting the cycle after the grant edge; exactly one is high.
- Starve counter:
  - increments on a D grant while req_i is high, saturating at STARVE_LIMIT.
  - clears on any I grant or when req_i is low.
- BUSY_x: hold all mem_* outputs stable until mem_ready is sampled high. On that edge:
  - mem_read/mem_write drop to 0.
  - x_rdata <= mem_rdata (D write-back: d_rdata is also updated but is don't-care).
  - x_ready pulses high for exactly one cycle.
  - state -> RELEASE.
- RELEASE: one cycle, no grant, so the served cache can drop its request. Then -> IDLE.
- Latency with no contention:
  - request seen in IDLE at cycle 0; mem strobe at cycle 1.
  - if mem_ready at cycle N, x_ready and x_rdata are valid at cycle N+1.
  - earliest next grant decision is at cycle N+2.
- The non-granted requester's ready stays 0; its request keeps waiting with no loss.
- mem_ready seen in IDLE or RELEASE is ignored.
- Request inputs changing while granted are ignored (registered copy is used).

Optional Feature:
- Macro ARB_RR_EN.
- When defined, simultaneous requests in IDLE alternate by round-robin: the pointer flips to the other requester after each grant, and STARVE_LIMIT is unused.
- When undefined, D has fixed priority with the starvation override described above.

Test Plan:
- Isolated I miss: i_read=1, i_addr=28'h0000010, memory returns 128'hA5..A5 after 5 cycles -> mem_read=1 with mem_addr=28'h0000010 from cycle 1 to ready; i_ready pulses 1 cycle with i_rdata=128'hA5..A5; d_ready stays 0.
- D write-back: d_write=1, d_addr=28'h0000200, d_wdata=128'h1234..; 3-cycle memory -> mem_write=1, mem_read=0, mem_wdata matches; single d_ready pulse; then RELEASE and IDLE.
- Simultaneous requests (fixed priority): i_read and d_read both asserted at cycle 0 -> D granted first; I granted at the IDLE following D's RELEASE; each cache gets its own rdata.
- Starvation (macro off, STARVE_LIMIT=4): I held high while D issues back-to-back requests -> after 4 D grants, the 5th grant goes to I.
- Round-robin (ARB_RR_EN defined): both requesting continuously -> grants alternate D, I, D, I.
- Reset mid-transaction: assert proc_reset during BUSY_D -> mem_read/mem_write drop to 0 the same cycle without a clock edge; no d_ready pulse; after release, a fresh i_read is served normally.
